stage_mem: RTL and testbench
============================

STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 SHALL have parameter DMEM_DEPTH, default 1024, data-memory depth in 32-bit words (power of two).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset.
REQ-003 SHALL have ports: Instr_EX in 32; ALUres in 32 (EX result / byte address); ALUb_Fwd in 32 (forwarded store data); ExtImm in 32.
REQ-004 SHALL have ports: MemWr_EX, MemRd_EX, MemSext_EX, RegWr_EX, Flush_EX  in  1 each; MemSize_EX in 2 (0 byte, 1 half, 2 word).
REQ-005 SHALL have ports: Instr_MEM, ALUres_MEM, ExtImm_MEM  out  32; RegWr_MEM  out  1 (EX/MEM register, feeds EX forwarding).
REQ-006 SHALL have ports: Instr_WB, ALUres_WB, ExtImm_WB, MemRd_WB  out  32; RegWr_WB, MisAlign_WB  out  1 (MEM/WB register).
REQ-007 One clock; reset is asynchronous and active-high.

Function
REQ-008 EX/MEM register SHALL capture Instr_EX, ALUres, ALUb_Fwd, ExtImm and all *_EX controls on every rising clk edge.
REQ-009 When Flush_EX=1 at an edge, EX/MEM SHALL load a bubble: Instr 0, all controls 0, data fields 0.
REQ-010 MEM/WB register SHALL capture Instr_MEM, ALUres_MEM, ExtImm_MEM, RegWr_MEM, load data and misalign flag each edge; no stall; total latency EX input to WB output = 2 cycles.
REQ-011 Word index SHALL be ALUres_MEM[log2(DMEM_DEPTH)+1:2]; upper address bits ignored (wrap modulo 4*DMEM_DEPTH bytes).
REQ-012 Misaligned access SHALL be: half with addr[0]=1, word with addr[1:0]!=0; MemSize=3 treated as word.
REQ-013 Store: when MemWr_MEM=1 and aligned, SHALL write at the edge ending the MEM cycle, byte lanes only: byte -> lane addr[1:0] gets store[7:0]; half -> lanes addr[1]*2..+1 get store[15:0]; word -> all lanes.
REQ-014 Misaligned store SHALL be suppressed (memory unchanged).
REQ-015 Load: array read combinational during MEM cycle; selected byte/half right-justified, sign-extended if MemSext_MEM=1 else zero-extended; registered into MemRd_WB.
REQ-016 Misaligned load SHALL give MemRd_WB=0; MisAlign_WB=1 for any misaligned load or store, else 0.
REQ-017 MemRd_WB SHALL be 0 when MemRd_MEM=0.
REQ-018 MemWr_MEM and MemRd_MEM both 1 SHALL perform the store and return pre-store data on MemRd_WB.
REQ-019 Load in MEM immediately after a store to same word SHALL return post-store data (no extra hazard logic).
REQ-020 Flush_EX SHALL NOT affect the instruction already in MEM; its store completes.

Reset
REQ-021 rst=1 SHALL asynchronously clear all EX/MEM and MEM/WB outputs and controls to 0 (Instr 0 = nop).
REQ-022 Data memory contents SHALL NOT be reset; no store SHALL occur while rst=1.
REQ-023 Reset mid-operation SHALL drop the in-flight store if rst is asserted before its write edge.

Configuration
REQ-024 Macro STAGE_MEM_BYTE_HALF_EN defined: byte/half accesses and sign extension per REQ-013/015.
REQ-025 Macro undefined: MemSize_EX and MemSext_EX ignored, every access is word; misalign only on addr[1:0]!=0.

Verification
REQ-026 sw 0x8899AABB to addr 0x10, then lw 0x10 -> MemRd_WB=0x8899AABB two cycles after lw enters, MisAlign_WB=0.
REQ-027 (BYTE_HALF_EN) after REQ-026 store, lb 0x13 -> 0xFFFFFF88; lbu 0x13 -> 0x00000088; lh 0x10 -> 0xFFFFAABB; sb 0x11 val 0x55 then lw -> 0x889955BB.
REQ-028 lw addr 0x12 -> MemRd_WB=0, MisAlign_WB=1; sw 0x7 val 0x1 -> memory unchanged, MisAlign_WB=1.
REQ-029 Flush_EX=1 with sw in EX -> next cycle Instr_MEM=0, RegWr_MEM=0, memory unchanged.
REQ-030 ALUres=0x1234 in EX -> ALUres_MEM=0x1234 after 1 edge, ALUres_WB=0x1234 after 2; assert rst mid-stream -> all outputs 0 immediately, no clock.
REQ-031 Address 4*DMEM_DEPTH+0x10 (DMEM_DEPTH=1024: 0x1010) reads word written at 0x10.

Source files
------------

// File: rtl/stage_mem.sv
// EX/MEM and MEM/WB pipeline registers with the data memory between them.
// Optional byte/half accesses: define STAGE_MEM_BYTE_HALF_EN.
module stage_mem #(
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr_EX,
  input  logic [31:0] ALUres,
  input  logic [31:0] ALUb_Fwd,
  input  logic [31:0] ExtImm,
  input  logic        MemWr_EX,
  input  logic        MemRd_EX,
  input  logic        MemSext_EX,
  input  logic        RegWr_EX,
  input  logic        Flush_EX,
  input  logic [1:0]  MemSize_EX,
  output logic [31:0] Instr_MEM,
  output logic [31:0] ALUres_MEM,
  output logic [31:0] ExtImm_MEM,
  output logic        RegWr_MEM,
  output logic [31:0] Instr_WB,
  output logic [31:0] ALUres_WB,
  output logic [31:0] ExtImm_WB,
  output logic [31:0] MemRd_WB,
  output logic        RegWr_WB,
  output logic        MisAlign_WB
);

  localparam int AW = $clog2(DMEM_DEPTH);

  logic [31:0] mem [DMEM_DEPTH];

  logic [31:0] st_m;
  logic        wr_m;
  logic        rd_m;
`ifdef STAGE_MEM_BYTE_HALF_EN
  logic [1:0]  sz_m;
  logic        sx_m;
`else
  logic        unused_cfg;
  assign unused_cfg = ^{MemSize_EX, MemSext_EX};
`endif

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [31:0]   rdata;
  logic [31:0]   ld;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic          mis;
  logic          we;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;

  assign idx   = ALUres_MEM[AW+1:2];
  assign off   = ALUres_MEM[1:0];
  assign rdata = mem[idx];
  assign ld_b  = rdata[{off, 3'b000} +: 8];
  assign ld_h  = off[1] ? rdata[31:16] : rdata[15:0];
  assign we    = wr_m & ~mis;

  // EX/MEM register: flush loads a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst || Flush_EX) begin
      Instr_MEM  <= '0;
      ALUres_MEM <= '0;
      ExtImm_MEM <= '0;
      RegWr_MEM  <= 1'b0;
      st_m       <= '0;
      wr_m       <= 1'b0;
      rd_m       <= 1'b0;
`ifdef STAGE_MEM_BYTE_HALF_EN
      sz_m       <= 2'd0;
      sx_m       <= 1'b0;
`endif
    end else begin
      Instr_MEM  <= Instr_EX;
      ALUres_MEM <= ALUres;
      ExtImm_MEM <= ExtImm;
      RegWr_MEM  <= RegWr_EX;
      st_m       <= ALUb_Fwd;
      wr_m       <= MemWr_EX;
      rd_m       <= MemRd_EX;
`ifdef STAGE_MEM_BYTE_HALF_EN
      sz_m       <= MemSize_EX;
      sx_m       <= MemSext_EX;
`endif
    end
  end

  // Lane enables, store replication, load extension, misalign
  always_comb begin
    mis   = 1'b0;
    be    = 4'hf;
    wdata = st_m;
    ld    = rdata;
`ifdef STAGE_MEM_BYTE_HALF_EN
    case (sz_m)
      2'd0: begin
        be    = 4'b0001 << off;
        wdata = {4{st_m[7:0]}};
        ld    = {{24{sx_m & ld_b[7]}}, ld_b};
      end
      2'd1: begin
        mis   = off[0];
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_m[15:0]}};
        ld    = {{16{sx_m & ld_h[15]}}, ld_h};
      end
      default: begin
        mis   = |off;
      end
    endcase
`else
    mis = |off;
`endif
  end

  // Data memory write at the edge ending MEM; never during reset
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // MEM/WB register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Instr_WB    <= '0;
      ALUres_WB   <= '0;
      ExtImm_WB   <= '0;
      MemRd_WB    <= '0;
      RegWr_WB    <= 1'b0;
      MisAlign_WB <= 1'b0;
    end else begin
      Instr_WB    <= Instr_MEM;
      ALUres_WB   <= ALUres_MEM;
      ExtImm_WB   <= ExtImm_MEM;
      MemRd_WB    <= (rd_m & ~mis) ? ld : 32'd0;
      RegWr_WB    <= RegWr_MEM;
      MisAlign_WB <= (wr_m | rd_m) & mis;
    end
  end

  // Lint guard for upper ld_h/ld_b use in word-only builds
  logic unused_ld;
  assign unused_ld = ^{ld_b, ld_h};

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: stimulus pushes expected WB results,
// a negedge monitor pops and compares whenever Instr_WB is non-zero.
module tb_stage_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] Instr_EX = '0;
  logic [31:0] ALUres = '0;
  logic [31:0] ALUb_Fwd = '0;
  logic [31:0] ExtImm = '0;
  logic        MemWr_EX = 1'b0;
  logic        MemRd_EX = 1'b0;
  logic        MemSext_EX = 1'b0;
  logic        RegWr_EX = 1'b0;
  logic        Flush_EX = 1'b0;
  logic [1:0]  MemSize_EX = 2'd0;
  logic [31:0] Instr_MEM, ALUres_MEM, ExtImm_MEM;
  logic        RegWr_MEM;
  logic [31:0] Instr_WB, ALUres_WB, ExtImm_WB, MemRd_WB;
  logic        RegWr_WB, MisAlign_WB;

  stage_mem #(.DMEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .Instr_EX(Instr_EX), .ALUres(ALUres),
    .ALUb_Fwd(ALUb_Fwd), .ExtImm(ExtImm),
    .MemWr_EX(MemWr_EX), .MemRd_EX(MemRd_EX),
    .MemSext_EX(MemSext_EX), .RegWr_EX(RegWr_EX),
    .Flush_EX(Flush_EX), .MemSize_EX(MemSize_EX),
    .Instr_MEM(Instr_MEM), .ALUres_MEM(ALUres_MEM),
    .ExtImm_MEM(ExtImm_MEM), .RegWr_MEM(RegWr_MEM),
    .Instr_WB(Instr_WB), .ALUres_WB(ALUres_WB),
    .ExtImm_WB(ExtImm_WB), .MemRd_WB(MemRd_WB),
    .RegWr_WB(RegWr_WB), .MisAlign_WB(MisAlign_WB)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] alu;
    logic [31:0] rd;
    logic        mis;
    logic        rw;
    int          due;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Monitor: one WB instruction per cycle when Instr_WB != 0
  always @(negedge clk) begin
    if (!rst && Instr_WB != 32'd0) begin
      if (sb.size() == 0) begin
        chk("unexpected_wb", Instr_WB, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_instr", Instr_WB, e.ins);
        chk("wb_latency", cyc, e.due);
        chk("wb_alures", ALUres_WB, e.alu);
        chk("wb_extimm", ExtImm_WB, ~e.ins);
        chk("wb_memrd", MemRd_WB, e.rd);
        chk("wb_misalign", {31'd0, MisAlign_WB}, {31'd0, e.mis});
        chk("wb_regwr", {31'd0, RegWr_WB}, {31'd0, e.rw});
      end
    end
  end

  task automatic op(input logic [31:0] ins, input logic wr,
                    input logic rd, input logic sx,
                    input logic [1:0] sz, input logic rw,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic fl, input logic push,
                    input logic [31:0] erd, input logic emis);
    @(negedge clk);
    Instr_EX   = ins;
    ALUres     = a;
    ALUb_Fwd   = d;
    ExtImm     = ~ins;
    MemWr_EX   = wr;
    MemRd_EX   = rd;
    MemSext_EX = sx;
    MemSize_EX = sz;
    RegWr_EX   = rw;
    Flush_EX   = fl;
    if (push)
      sb.push_back('{ins, a, erd, emis, rw, cyc + 2});
  endtask

  task automatic idle();
    op(32'd0, 0, 0, 0, 2'd0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0);
  endtask

  task automatic sw(input logic [31:0] ins, input logic [31:0] a,
                    input logic [31:0] d, input logic emis);
    op(ins, 1, 0, 0, 2'd2, 0, a, d, 0, 1, 32'd0, emis);
  endtask

  task automatic lw(input logic [31:0] ins, input logic [31:0] a,
                    input logic [31:0] erd, input logic emis);
    op(ins, 0, 1, 0, 2'd2, 1, a, 32'd0, 0, 1, erd, emis);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_instr_mem", Instr_MEM, 32'd0);
    chk("rst_alures_mem", ALUres_MEM, 32'd0);
    chk("rst_regwr_mem", {31'd0, RegWr_MEM}, 32'd0);
    chk("rst_instr_wb", Instr_WB, 32'd0);
    chk("rst_memrd_wb", MemRd_WB, 32'd0);
    chk("rst_mis_wb", {31'd0, MisAlign_WB}, 32'd0);
    rst = 1'b0;

    sw(32'h101, 32'h4, 32'hCAFEF00D, 0);
    sw(32'h102, 32'h10, 32'h8899AABB, 0);
    lw(32'h103, 32'h10, 32'h8899AABB, 0);
    lw(32'h104, 32'h1010, 32'h8899AABB, 0);
    lw(32'h105, 32'h12, 32'd0, 1);
    sw(32'h106, 32'h7, 32'h1, 1);
    lw(32'h107, 32'h4, 32'hCAFEF00D, 0);

    op(32'h108, 1, 0, 0, 2'd2, 0, 32'h4, 32'hDEADBEEF,
       1, 0, 32'd0, 0);
    idle();
    chk("flush_instr_mem", Instr_MEM, 32'd0);
    chk("flush_regwr_mem", {31'd0, RegWr_MEM}, 32'd0);
    lw(32'h109, 32'h4, 32'hCAFEF00D, 0);

    sw(32'h10A, 32'h20, 32'h11111111, 0);
    op(32'h10B, 1, 1, 0, 2'd2, 1, 32'h20, 32'h22222222,
       0, 1, 32'h11111111, 0);
    lw(32'h10C, 32'h20, 32'h22222222, 0);
    op(32'h10D, 0, 0, 0, 2'd2, 1, 32'h10, 32'd0, 0, 1, 32'd0, 0);

    sw(32'h10E, 32'h30, 32'hA5A5A5A5, 0);
    op(32'h10F, 1, 0, 0, 2'd2, 0, 32'h30, 32'd0, 1, 0, 32'd0, 0);
    lw(32'h110, 32'h30, 32'hA5A5A5A5, 0);

`ifdef STAGE_MEM_BYTE_HALF_EN
    op(32'h111, 0, 1, 1, 2'd0, 1, 32'h13, 32'd0, 0, 1, 32'hFFFFFF88, 0);
    op(32'h112, 0, 1, 0, 2'd0, 1, 32'h13, 32'd0, 0, 1, 32'h00000088, 0);
    op(32'h113, 0, 1, 1, 2'd1, 1, 32'h10, 32'd0, 0, 1, 32'hFFFFAABB, 0);
    op(32'h114, 1, 0, 0, 2'd0, 0, 32'h11, 32'h55, 0, 1, 32'd0, 0);
    lw(32'h115, 32'h10, 32'h889955BB, 0);
    op(32'h116, 0, 1, 1, 2'd1, 1, 32'h11, 32'd0, 0, 1, 32'd0, 1);
`else
    op(32'h111, 0, 1, 1, 2'd0, 1, 32'h13, 32'd0, 0, 1, 32'd0, 1);
    op(32'h112, 0, 1, 1, 2'd1, 1, 32'h10, 32'd0, 0, 1, 32'h8899AABB, 0);
`endif

    op(32'h120, 0, 0, 0, 2'd2, 1, 32'h1234, 32'd0, 0, 1, 32'd0, 0);
    op(32'h121, 1, 0, 0, 2'd2, 0, 32'h4, 32'hBAD, 0, 0, 32'd0, 0);
    chk("alures_mem_1edge", ALUres_MEM, 32'h1234);
    @(negedge clk);
    Instr_EX = '0; MemWr_EX = 0; MemRd_EX = 0; RegWr_EX = 0;
    chk("alures_wb_2edge", ALUres_WB, 32'h1234);
    chk("store_in_mem", Instr_MEM, 32'h121);
    #2 rst = 1'b1;
    #1;
    chk("arst_instr_mem", Instr_MEM, 32'd0);
    chk("arst_alures_mem", ALUres_MEM, 32'd0);
    chk("arst_extimm_mem", ExtImm_MEM, 32'd0);
    chk("arst_instr_wb", Instr_WB, 32'd0);
    chk("arst_alures_wb", ALUres_WB, 32'd0);
    chk("arst_extimm_wb", ExtImm_WB, 32'd0);
    chk("arst_regwr", {30'd0, RegWr_MEM, RegWr_WB}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lw(32'h122, 32'h4, 32'hCAFEF00D, 0);
    idle();

    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
